reg_file_stream_reader: RTL and testbench
=========================================

# reg_file_stream_reader

Read-side sequencer for the 1-write/2-read hypervector register file. On a start command it walks a contiguous, wrapping range of register addresses through one combinational read port. It emits each register as a beat on a valid/ready stream toward downstream encoders or the associative memory. Each beat is captured in an output register, so data is a snapshot at load time and the block sustains one beat per cycle.

## Interface
- DataWidth, 512, width of one register / stream beat
- NumRegs, 4, number of registers in the attached file; must be ≥ 2
- NumRegsWidth, $clog2(NumRegs), derived, not overridden
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  start command, sampled only in IDLE
- start_addr_i  input  NumRegsWidth  first register to read
- num_words_i  input  NumRegsWidth+1  beats to emit; larger than NumRegs re-reads with wrap
- busy_o  output  1  high in STREAM or DRAIN
- done_o  output  1  one-cycle pulse at completion
- rd_addr_o  output  NumRegsWidth  to register file read port address
- rd_data_i  input  DataWidth  from register file read port data (combinational)
- data_o  output  DataWidth  stream beat
- valid_o  output  1  beat valid
- ready_i  input  1  downstream accept
- last_o  output  1  final beat marker (only with REG_STREAM_LAST_EN)

## Operation
- States: IDLE, STREAM, DRAIN. Reset → IDLE. Reset values: busy_o=0, done_o=0, rd_addr_o=0, data_o=0, valid_o=0, last_o=0, internal counters 0.
- IDLE:
  - start_i=1 with num_words_i≠0 latches addr=start_addr_i and remaining=num_words_i, then goes to STREAM.
  - start_addr_i ≥ NumRegs is replaced by 0.
  - start_i=1 with num_words_i=0 stays in IDLE and pulses done_o the next cycle.
- rd_addr_o is registered and equals the current addr in STREAM; outside STREAM it holds its last value.
- Load condition: state=STREAM and (valid_o=0 or ready_i=1). On load:
  - data_o←rd_data_i and valid_o←1.
  - addr←(addr==NumRegs-1)?0:addr+1.
  - remaining←remaining-1.
- When the load takes remaining from 1 to 0, go to DRAIN.
- DRAIN: no loads. When valid_o&&ready_i, valid_o←0, done_o←1 for that next cycle, and the state returns to IDLE.
- In STREAM, a handshake without load cannot occur: every accepted beat is replaced in the same cycle.
- valid_o, once high, holds with data_o stable until ready_i=1. This is AXI-stream style; ready_i may depend on valid_o.
- start_i in STREAM/DRAIN is ignored; no queuing.
- Register file writes after a beat is loaded do not change that beat. Writes to not-yet-read addresses are visible.
- Asynchronous reset mid-stream aborts immediately to reset values. No done_o is produced.

## Timing
- Cycle 0: start_i sampled in IDLE. Cycle 1: STREAM, rd_addr_o=start addr. Cycle 2: first valid_o=1.
- Start-to-first-beat latency: 2 cycles.
- With ready_i held high: N beats on consecutive cycles 2..N+1, done_o high in cycle N+2, IDLE in cycle N+2.
- Earliest next accepted start_i: cycle N+2.
- Backpressure: each cycle ready_i=0 with valid_o=1 stalls address advance and counters by exactly one cycle.
- done_o never coincides with valid_o of the same command.

## Configuration
- REG_STREAM_LAST_EN defined: last_o port exists; it is registered and set together with the load of the final beat. It clears when that beat is accepted and resets to 0.
- Not defined: no last_o port; consumers count beats themselves. All other behaviour is identical.

## Test plan
- Basic stream: NumRegs=4; regs=A,B,C,D; start_addr=1, num_words=3, ready_i=1.
  - Beats B,C,D in cycles 2,3,4.
  - done_o in cycle 5; busy_o high cycles 1–4.
- Wrap and over-length: start_addr=3, num_words=6.
  - Beats D,A,B,C,D,A; rd_addr_o sequence 3,0,1,2,3,0.
  - last_o high only with the final A when the macro is defined.
- Backpressure: num_words=4, ready_i toggles 1,0,0,1,…
  - data_o/valid_o stable during stalls; no beat dropped or duplicated.
  - done_o exactly one cycle after the 4th handshake.
- Zero and ignored starts:
  - num_words=0 → no valid_o, done_o pulse next cycle.
  - start_i pulsed mid-stream → stream unchanged, a single done_o.
- Snapshot/write race: write X to reg 2 in the cycle after reg 2's beat loads while stalled.
  - The stalled beat keeps the old value; a later re-read of reg 2 returns X.
- Reset mid-stream: assert rst_ni=0 during the 2nd beat.
  - All outputs go 0 asynchronously; no done_o.
  - A new start after release streams normally from cycle 2.

Source files
------------

// File: rtl/reg_file_stream_reader.sv
// reg_file_stream_reader: read-side sequencer for the 1W/2R hypervector
// register file. A start command walks a contiguous, wrapping range of
// register addresses through one combinational read port and emits each
// register as a registered beat on a valid/ready stream.
//
// Optional feature: define REG_STREAM_LAST_EN to add the last_o port, a
// registered marker that is high alongside the final beat of a command.
module reg_file_stream_reader #(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned NumRegs   = 4,
  localparam int unsigned NumRegsWidth = $clog2(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NumRegsWidth-1:0] start_addr_i,
  input  logic [NumRegsWidth:0]   num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NumRegsWidth-1:0] rd_addr_o,
  input  logic [DataWidth-1:0]    rd_data_i,
  output logic [DataWidth-1:0]    data_o,
  output logic                    valid_o,
  input  logic                    ready_i
`ifdef REG_STREAM_LAST_EN
  ,
  output logic                    last_o
`endif
);

  localparam int unsigned CntWidth = NumRegsWidth + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NumRegsWidth-1:0] addr_q;
  logic [CntWidth-1:0]     remaining_q;
  logic                    load;
  logic                    start_go;
  logic                    done_d;
  logic                    final_load;
  logic [NumRegsWidth-1:0] start_addr_ok;
  logic [NumRegsWidth-1:0] addr_next;

  // Out-of-range start addresses fall back to register 0; the walk wraps at NumRegs.
  assign start_addr_ok = (32'(start_addr_i) < NumRegs) ? start_addr_i : '0;
  assign addr_next     = (addr_q == NumRegsWidth'(NumRegs - 1)) ? '0
                                                                : addr_q + NumRegsWidth'(1);
  assign final_load    = load && (remaining_q == CntWidth'(1));

  assign busy_o    = (state_q != IDLE);
  assign rd_addr_o = addr_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus load/start/done strobes.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    start_go = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_words_i != '0) begin
            start_go = 1'b1;
            state_d  = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        // An accepted beat is always replaced in the same cycle, so the
        // output register never empties while words remain.
        if (!valid_o || ready_i) begin
          load = 1'b1;
          if (remaining_q == CntWidth'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (valid_o && ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address walker and beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (start_go) begin
      addr_q      <= start_addr_ok;
      remaining_q <= num_words_i;
    end else if (load) begin
      addr_q      <= addr_next;
      remaining_q <= remaining_q - CntWidth'(1);
    end
  end

  // Output beat register: data is a snapshot of the read port at load time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      data_o  <= rd_data_i;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the final handshake or a zero-length start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_o <= 1'b0;
    end else begin
      done_o <= done_d;
    end
  end

`ifdef REG_STREAM_LAST_EN
  // Final-beat marker travels with the beat and drops once it is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_o <= 1'b0;
    end else if (load) begin
      last_o <= final_load;
    end else if (valid_o && ready_i) begin
      last_o <= 1'b0;
    end
  end
`else
  // Without the marker the final-load decode has no consumer.
  logic unused_final_load;
  assign unused_final_load = final_load;
`endif

endmodule

// File: tb/tb_reg_file_stream_reader.sv
// Directed testbench for reg_file_stream_reader (DataWidth=512, NumRegs=4).
module tb_reg_file_stream_reader;

  localparam int DW = 512;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [1:0]    start_addr_i;
  logic [2:0]    num_words_i;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    rd_addr_o;
  logic [DW-1:0] rd_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
`ifdef REG_STREAM_LAST_EN
  logic          last_o;
`endif

  logic [DW-1:0] regs [4];
  logic [DW-1:0] exp_beats [8];
  int tests = 0;
  int fails = 0;

  assign rd_data_i = regs[rd_addr_o];

  reg_file_stream_reader #(.DataWidth(DW), .NumRegs(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .num_words_i  (num_words_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
`ifdef REG_STREAM_LAST_EN
    ,
    .last_o       (last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] sa;
    logic [2:0] nw;
    int         idx [8];
  } vec_t;

  vec_t vec [5];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_init(input int i);
    logic [31:0] w;
    w = 32'h1111_1111 * (i + 1);
    return {16{w}};
  endfunction

  // Stream one table entry with ready_i held high and check exact cycle timing.
  task automatic run_vec(input int v);
    int n;
    n = int'(vec[v].nw);
    ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1; start_addr_i = vec[v].sa; num_words_i = vec[v].nw;
    check("idle_busy", busy_o, 0);
    @(negedge clk_i);
    start_i = 1'b0;
    check("c1_busy", busy_o, 1);
    check("c1_valid", valid_o, 0);
    check("c1_rd_addr", rd_addr_o, vec[v].idx[0]);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      check("beat_valid", valid_o, 1);
      check("beat_data", data_o, regs[vec[v].idx[k]]);
      check("beat_done_low", done_o, 0);
      if (k + 1 < n) check("rd_addr_seq", rd_addr_o, vec[v].idx[k+1]);
`ifdef REG_STREAM_LAST_EN
      check("last", last_o, (k == n - 1) ? 1 : 0);
`endif
    end
    @(negedge clk_i);
    check("done_pulse", done_o, 1);
    check("done_valid_low", valid_o, 0);
    check("done_busy_low", busy_o, 0);
    @(negedge clk_i);
    check("done_single", done_o, 0);
  endtask

  // Stream with a ready_i pattern (bit c-2 for cycle c), optional register
  // write and optional ignored start pulse; expected beats come from exp_beats.
  task automatic run_bp(input logic [1:0] sa, input logic [2:0] nw, input logic [15:0] pat,
                        input int wr_cyc, input int wr_idx, input logic [DW-1:0] wr_val,
                        input int st_cyc);
    int cnt, last_hs;
    bit pv, pr, seen_done;
    logic [DW-1:0] pd;
    cnt = 0; last_hs = -10; pv = 0; pr = 0; pd = '0; seen_done = 0;
    ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1; start_addr_i = sa; num_words_i = nw;
    for (int cyc = 1; cyc < 60 && !seen_done; cyc++) begin
      @(negedge clk_i);
      start_i = (cyc == st_cyc);
      if (start_i) begin start_addr_i = 2'd2; num_words_i = 3'd7; end
      ready_i = (cyc >= 2) ? pat[(cyc - 2) % 16] : 1'b1;
      if (cyc == wr_cyc) regs[wr_idx] = wr_val;
      if (pv && !pr) begin
        check("stall_valid", valid_o, 1);
        check("stall_data", data_o, pd);
      end
      if (done_o) begin
        seen_done = 1;
        check("bp_done_timing", cyc, last_hs + 1);
        check("bp_beat_count", cnt, int'(nw));
        check("bp_done_valid", valid_o, 0);
      end else if (valid_o && ready_i) begin
        if (cnt < 8) check("bp_beat_data", data_o, exp_beats[cnt]);
        else check("bp_extra_beat", cnt, int'(nw));
`ifdef REG_STREAM_LAST_EN
        check("bp_last", last_o, (cnt == int'(nw) - 1) ? 1 : 0);
`endif
        cnt++;
        last_hs = cyc;
      end
      pv = valid_o; pr = ready_i; pd = data_o;
    end
    start_i = 1'b0;
    if (!seen_done) check("bp_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_no_extra_done", done_o, 0);
      check("bp_idle_valid", valid_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] x_val;
    x_val = {16{32'hDEAD_BEEF}};
    for (int i = 0; i < 4; i++) regs[i] = reg_init(i);

    vec[0] = '{sa: 2'd1, nw: 3'd3, idx: '{1, 2, 3, 0, 0, 0, 0, 0}};
    vec[1] = '{sa: 2'd3, nw: 3'd6, idx: '{3, 0, 1, 2, 3, 0, 0, 0}};
    vec[2] = '{sa: 2'd0, nw: 3'd1, idx: '{0, 0, 0, 0, 0, 0, 0, 0}};
    vec[3] = '{sa: 2'd2, nw: 3'd4, idx: '{2, 3, 0, 1, 0, 0, 0, 0}};
    vec[4] = '{sa: 2'd0, nw: 3'd7, idx: '{0, 1, 2, 3, 0, 1, 2, 0}};

    rst_ni = 1'b0; start_i = 1'b0; start_addr_i = '0; num_words_i = '0; ready_i = 1'b1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
`ifdef REG_STREAM_LAST_EN
    check("rst_last", last_o, 0);
`endif
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Zero-length start: no beat, done the next cycle.
    @(negedge clk_i);
    start_i = 1'b1; start_addr_i = 2'd1; num_words_i = 3'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    check("zero_done", done_o, 1);
    check("zero_busy", busy_o, 0);
    check("zero_valid", valid_o, 0);
    @(negedge clk_i);
    check("zero_done_single", done_o, 0);
    check("zero_valid2", valid_o, 0);

    // Backpressure 1,0,0,1 with an ignored start pulse mid-stream.
    for (int i = 0; i < 4; i++) exp_beats[i] = regs[i];
    run_bp(2'd0, 3'd4, 16'h9999, -1, 0, '0, 4);

    // Snapshot race: reg 2 rewritten while its beat is stalled, re-read later.
    exp_beats[0] = regs[2]; exp_beats[1] = regs[3]; exp_beats[2] = regs[0];
    exp_beats[3] = regs[1]; exp_beats[4] = x_val;
    run_bp(2'd2, 3'd5, 16'hFFFC, 2, 2, x_val, -1);
    regs[2] = reg_init(2);

    // Asynchronous reset during the second beat.
    ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1; start_addr_i = 2'd0; num_words_i = 3'd4;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("pre_rst_beat2", data_o, regs[1]);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_data", data_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_rd_addr", rd_addr_o, 0);
    check("arst_done", done_o, 0);
`ifdef REG_STREAM_LAST_EN
    check("arst_last", last_o, 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_no_done", done_o, 0);
      check("post_rst_no_valid", valid_o, 0);
    end
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
